// File: rtl/stego_pkg.sv
// -----------------------------------------------------------------------------
// stego_pkg
// Shared types and constants for the EMD steganography engine.
//   state_t      : engine FSM states. ST_CHECK exists only when the
//                  STEGO_SELF_CHECK_EN macro is defined.
//   digit_act_t  : per-pixel action chosen by one balanced-ternary digit.
//   pow3()       : constant 3^n, used for the modulus M = 3^NUM_PIX.
//   pix_top()    : largest pixel code for a given width (upper clamp trigger).
//   CLAMP_*      : lower clamp trigger/replacement values.
// -----------------------------------------------------------------------------
package stego_pkg;

`ifdef STEGO_SELF_CHECK_EN
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLAMP  = 3'd1,
        ST_HORNER = 3'd2,
        ST_SOLVE  = 3'd3,
        ST_DIGIT  = 3'd4,
        ST_OUT    = 3'd5,
        ST_CHECK  = 3'd6
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLAMP  = 3'd1,
        ST_HORNER = 3'd2,
        ST_SOLVE  = 3'd3,
        ST_DIGIT  = 3'd4,
        ST_OUT    = 3'd5
    } state_t;
`endif

    typedef enum logic [1:0] {
        ACT_KEEP = 2'd0,
        ACT_INC  = 2'd1,
        ACT_DEC  = 2'd2
    } digit_act_t;

    // A pixel at CLAMP_LO_FROM is lifted to CLAMP_LO_TO so a -1 cannot underflow.
    localparam int CLAMP_LO_FROM = 0;
    localparam int CLAMP_LO_TO   = 1;

    function automatic int pow3(input int n);
        int p;
        p = 1;
        for (int k = 0; k < n; k++) p = p * 3;
        return p;
    endfunction

    // The top code is lowered by one so a +1 cannot overflow.
    function automatic int pix_top(input int pw);
        return (1 << pw) - 1;
    endfunction

endpackage

// File: rtl/stego_ternary_step.sv
// -----------------------------------------------------------------------------
// stego_ternary_step
// One balanced-ternary digit of the residual s (combinational).
//   s      in  : current residual
//   s_next out : residual for the next digit; a digit of 2 is taken as -1,
//                so it carries one into the higher digits before dividing
//   act    out : pixel action for this digit (KEEP / INC / DEC)
// -----------------------------------------------------------------------------
module stego_ternary_step
    import stego_pkg::*;
#(
    parameter int SW = 6
) (
    input  logic [SW-1:0] s,
    output logic [SW-1:0] s_next,
    output digit_act_t    act
);

    logic [SW-1:0] r;

    always_comb begin
        r      = s % SW'(3);
        act    = ACT_KEEP;
        s_next = s / SW'(3);
        case (r)
            SW'(1): act = ACT_INC;
            SW'(2): begin
                act    = ACT_DEC;
                s_next = (s + SW'(1)) / SW'(3);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/stego_emd_engine.sv
// -----------------------------------------------------------------------------
// stego_emd_engine
// Exploiting-modification-direction steganography engine for a group of
// NUM_PIX pixels. Embed hides one symbol modulo M = 3^NUM_PIX by moving each
// pixel by at most one step; extract recovers it as sum(g_i * 3^i) mod M.
//
// Ports:
//   clk, rst   clock; synchronous active-low reset
//   in_valid / in_ready   input group handshake (ready only in IDLE)
//   mode       0 = embed, 1 = extract (captured on accept)
//   pix_in     pixel i at [i*PIXEL_WIDTH +: PIXEL_WIDTH]
//   secret     symbol to embed (ignored in extract)
//   out_valid / out_ready result handshake; outputs hold while stalled
//   pix_out    stego pixels (embed), zero in extract
//   mess_out   extracted symbol (extract), zero in embed
//   out_err    secret >= M (embed)
//   busy       high outside IDLE
//
// Optional macro STEGO_SELF_CHECK_EN: adds a CHECK state that re-extracts the
// stego pixels and also flags out_err when they do not decode to secret mod M.
// -----------------------------------------------------------------------------
module stego_emd_engine
    import stego_pkg::*;
#(
    parameter int PIXEL_WIDTH = 8,
    parameter int NUM_PIX     = 3,
    parameter int MESS_WIDTH  = 5
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic                           mode,
    input  logic [NUM_PIX*PIXEL_WIDTH-1:0] pix_in,
    input  logic [MESS_WIDTH-1:0]          secret,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [NUM_PIX*PIXEL_WIDTH-1:0] pix_out,
    output logic [MESS_WIDTH-1:0]          mess_out,
    output logic                           out_err,
    output logic                           busy
);

    localparam int M  = pow3(NUM_PIX);
    localparam int FW = $clog2(M);
    localparam int IW = FW + PIXEL_WIDTH + 2;
    localparam int SW = FW + 1;
    localparam int DW = ((MESS_WIDTH > FW) ? MESS_WIDTH : FW) + 2;
    localparam int XW = (NUM_PIX > 1) ? $clog2(NUM_PIX) : 1;
    localparam logic [XW-1:0]          IDX_LAST  = XW'(NUM_PIX - 1);
    localparam logic [PIXEL_WIDTH-1:0] PIX_TOP   = PIXEL_WIDTH'(pix_top(PIXEL_WIDTH));
    localparam logic [PIXEL_WIDTH-1:0] PIX_TOP_TO = PIX_TOP - PIXEL_WIDTH'(1);
    localparam logic [PIXEL_WIDTH-1:0] PIX_LO    = PIXEL_WIDTH'(CLAMP_LO_FROM);
    localparam logic [PIXEL_WIDTH-1:0] PIX_LO_TO = PIXEL_WIDTH'(CLAMP_LO_TO);

    state_t                   state_reg, state_next;
    logic [PIXEL_WIDTH-1:0]   pix_reg   [NUM_PIX];
    logic [PIXEL_WIDTH-1:0]   pix_next  [NUM_PIX];
    logic [PIXEL_WIDTH-1:0]   clamp_val [NUM_PIX];
    logic [NUM_PIX*PIXEL_WIDTH-1:0] pix_next_flat;
    logic [FW-1:0]            f_reg, f_next, f_step;
    logic [SW-1:0]            s_reg, s_next, s_stepped, s_solved;
    logic [XW-1:0]            idx_reg, idx_next;
    logic                     mode_reg;
    logic [MESS_WIDTH-1:0]    secret_reg;
    logic                     err_reg, err_next, solve_err, check_err;
    logic [IW-1:0]            horner_sum;
    logic [DW-1:0]            diff;
    digit_act_t               step_act;
    logic                     accept;

    logic [NUM_PIX*PIXEL_WIDTH-1:0] pix_out_reg;
    logic [MESS_WIDTH-1:0]          mess_out_reg;
    logic                           out_err_reg;

    assign accept = in_valid && in_ready;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PIX; gi++) begin : g_pix
            assign clamp_val[gi] = (pix_reg[gi] == PIX_TOP) ? PIX_TOP_TO :
                                   (pix_reg[gi] == PIX_LO)  ? PIX_LO_TO  : pix_reg[gi];
            assign pix_next_flat[gi*PIXEL_WIDTH +: PIXEL_WIDTH] = pix_next[gi];
        end
    endgenerate

    // One Horner step over the pixel selected by idx_reg (MSB pixel first).
    assign horner_sum = IW'(f_reg) * IW'(3) + IW'(pix_reg[idx_reg]);
    assign f_step     = FW'(horner_sum % IW'(M));

    // Residual to add: (secret - f) mod M, computed without going negative.
    assign solve_err = DW'(secret_reg) >= DW'(M);
    assign diff      = DW'(secret_reg) + DW'(M) - DW'(f_reg);
    assign s_solved  = (diff >= DW'(M)) ? SW'(diff - DW'(M)) : SW'(diff);

`ifdef STEGO_SELF_CHECK_EN
    assign check_err = MESS_WIDTH'(f_step) != (secret_reg % MESS_WIDTH'(M));
`else
    assign check_err = 1'b0;
`endif

    stego_ternary_step #(.SW(SW)) u_step (
        .s      (s_reg),
        .s_next (s_stepped),
        .act    (step_act)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst) state_reg <= ST_IDLE;
        else      state_reg <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:   if (accept) state_next = mode ? ST_HORNER : ST_CLAMP;
            ST_CLAMP:  state_next = ST_HORNER;
            ST_HORNER: if (idx_reg == '0) state_next = mode_reg ? ST_OUT : ST_SOLVE;
            ST_SOLVE:  state_next = ST_DIGIT;
`ifdef STEGO_SELF_CHECK_EN
            ST_DIGIT:  if (idx_reg == IDX_LAST) state_next = ST_CHECK;
            ST_CHECK:  if (idx_reg == '0) state_next = ST_OUT;
`else
            ST_DIGIT:  if (idx_reg == IDX_LAST) state_next = ST_OUT;
`endif
            ST_OUT:    if (out_ready) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        in_ready  = (state_reg == ST_IDLE);
        busy      = (state_reg != ST_IDLE);
        out_valid = (state_reg == ST_OUT);
    end

    // Datapath next values
    always_comb begin
        for (int k = 0; k < NUM_PIX; k++) pix_next[k] = pix_reg[k];
        f_next   = f_reg;
        s_next   = s_reg;
        err_next = err_reg;
        idx_next = idx_reg;
        case (state_reg)
            ST_IDLE: if (accept) begin
                for (int k = 0; k < NUM_PIX; k++)
                    pix_next[k] = pix_in[k*PIXEL_WIDTH +: PIXEL_WIDTH];
                f_next   = '0;
                err_next = 1'b0;
                idx_next = IDX_LAST;
            end
            ST_CLAMP: for (int k = 0; k < NUM_PIX; k++) pix_next[k] = clamp_val[k];
            ST_HORNER: begin
                f_next   = f_step;
                idx_next = (idx_reg == '0) ? '0 : idx_reg - XW'(1);
            end
            ST_SOLVE: begin
                err_next = solve_err;
                s_next   = solve_err ? '0 : s_solved;
                idx_next = '0;
            end
            ST_DIGIT: begin
                case (step_act)
                    ACT_INC: pix_next[idx_reg] = pix_reg[idx_reg] + PIXEL_WIDTH'(1);
                    ACT_DEC: pix_next[idx_reg] = pix_reg[idx_reg] - PIXEL_WIDTH'(1);
                    default: ;
                endcase
                s_next = s_stepped;
                if (idx_reg == IDX_LAST) begin
                    idx_next = IDX_LAST;
                    f_next   = '0;
                end else begin
                    idx_next = idx_reg + XW'(1);
                end
            end
`ifdef STEGO_SELF_CHECK_EN
            ST_CHECK: begin
                f_next   = f_step;
                idx_next = (idx_reg == '0) ? '0 : idx_reg - XW'(1);
            end
`endif
            default: ;
        endcase
    end

    // Datapath and result registers; results are latched on entry to OUT
    // so they stay frozen for the whole stall.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < NUM_PIX; k++) pix_reg[k] <= '0;
            f_reg        <= '0;
            s_reg        <= '0;
            idx_reg      <= '0;
            err_reg      <= 1'b0;
            mode_reg     <= 1'b0;
            secret_reg   <= '0;
            pix_out_reg  <= '0;
            mess_out_reg <= '0;
            out_err_reg  <= 1'b0;
        end else begin
            for (int k = 0; k < NUM_PIX; k++) pix_reg[k] <= pix_next[k];
            f_reg   <= f_next;
            s_reg   <= s_next;
            idx_reg <= idx_next;
            err_reg <= err_next;
            if (accept) begin
                mode_reg   <= mode;
                secret_reg <= secret;
            end
            if (state_reg != ST_OUT && state_next == ST_OUT) begin
                if (mode_reg) begin
                    pix_out_reg  <= '0;
                    mess_out_reg <= MESS_WIDTH'(f_next);
                    out_err_reg  <= 1'b0;
                end else begin
                    pix_out_reg  <= pix_next_flat;
                    mess_out_reg <= '0;
                    out_err_reg  <= err_reg | check_err;
                end
            end
        end
    end

    assign pix_out  = pix_out_reg;
    assign mess_out = mess_out_reg;
    assign out_err  = out_err_reg;

endmodule
